// File: rtl/pwm_gen_multi_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pwm_gen_multi_if                                              |
// | Purpose  : Register-file side bundle for pwm_gen_multi. Carries the      |
// |            global enable, time-base configuration, per-channel config,   |
// |            the load request and all status/PWM outputs.                  |
// | Ports    : master = register file / bench (drives config, reads status)  |
// |            slave  = pwm_gen_multi (reads config, drives status)          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface pwm_gen_multi_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  logic                      en;
  logic [WIDTH-1:0]          cfg_period;
  logic [7:0]                cfg_prescale;
  logic                      cfg_center;
  logic [2*CHANNELS-1:0]     ch_mode;
  logic [WIDTH*CHANNELS-1:0] ch_cmp1;
  logic [WIDTH*CHANNELS-1:0] ch_cmp2;
  logic [CHANNELS-1:0]       ch_en;
  logic                      load;
  logic                      load_pending;
  logic [WIDTH-1:0]          count;
  logic                      period_end;
  logic [CHANNELS-1:0]       pwm_out;

  modport master (
    output en, cfg_period, cfg_prescale, cfg_center, ch_mode,
           ch_cmp1, ch_cmp2, ch_en, load,
    input  load_pending, count, period_end, pwm_out
  );

  modport slave (
    input  en, cfg_period, cfg_prescale, cfg_center, ch_mode,
           ch_cmp1, ch_cmp2, ch_en, load,
    output load_pending, count, period_end, pwm_out
  );
endinterface
`default_nettype wire

// File: rtl/pwm_gen_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pwm_gen_multi                                                 |
// | Purpose  : Multi-channel PWM generator with a prescaled edge- or         |
// |            center-aligned time base and shadowed configuration that is   |
// |            only applied at period boundaries.                            |
// | Ports    : clk - peripheral clock                                        |
// |            rst - asynchronous active-high reset                          |
// |            bus - pwm_gen_multi_if.slave: en, cfg_*, ch_*, load in;       |
// |                  load_pending, count, period_end, pwm_out out            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pwm_gen_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic            clk,
  input  logic            rst,
  pwm_gen_multi_if.slave  bus
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  // Active (shadow) configuration set
  logic [WIDTH-1:0]          period_q,   period_d;
  logic [7:0]                prescale_q, prescale_d;
  logic                      center_q,   center_d;
  logic [2*CHANNELS-1:0]     mode_q,     mode_d;
  logic [WIDTH*CHANNELS-1:0] cmp1_q,     cmp1_d;
  logic [WIDTH*CHANNELS-1:0] cmp2_q,     cmp2_d;

  // Time base and status
  logic [7:0]                psc_q,          psc_d;
  logic [WIDTH-1:0]          count_q,        count_d;
  dir_e                      dir_q,          dir_d;
  logic                      load_pending_q, load_pending_d;
  logic                      period_end_q,   period_end_d;
  logic [CHANNELS-1:0]       pwm_q,          pwm_d;

  logic                      tick;
  logic                      at_top;
  logic                      step_down;
  logic                      boundary;
  logic                      copy_cfg;
  logic [CHANNELS-1:0]       ch_hit;

  // Compare function for one channel against the registered count.
  function automatic logic cmp_hit(
    input logic [1:0]       mode,
    input logic [WIDTH-1:0] c,
    input logic [WIDTH-1:0] c1,
    input logic [WIDTH-1:0] c2
  );
    logic below1;
    logic win;
    below1 = (c < c1);
    // cmp1 >= cmp2 leaves this empty without a separate test
    win    = !below1 && (c < c2);
    case (mode)
      2'b00:   cmp_hit = below1;
      2'b01:   cmp_hit = !below1;
      2'b10:   cmp_hit = win;
      default: cmp_hit = !win;
    endcase
  endfunction

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign ch_hit[i] = cmp_hit(mode_q[2*i +: 2],
                                 count_q,
                                 cmp1_q[WIDTH*i +: WIDTH],
                                 cmp2_q[WIDTH*i +: WIDTH]);
    end
  endgenerate

  // Tick and period-boundary detection
  always_comb begin
    tick      = bus.en && (psc_q == prescale_q);
    at_top    = (count_q == period_q);
    // At the top the next step is always downward, even if dir_q still says
    // up; this also makes P=1 in center mode produce its boundary at count 1.
    step_down = (dir_q == DIR_DOWN) || at_top;
    if (period_q == '0) begin
      boundary = tick;
    end else if (center_q) begin
      boundary = tick && (count_q == CNT_ONE) && step_down;
    end else begin
      boundary = tick && at_top;
    end
    // Disabled: load copies straight away. Enabled: only on a boundary tick,
    // including a load that arrives on the boundary tick itself.
    copy_cfg = bus.en ? (boundary && (bus.load || load_pending_q)) : bus.load;
  end

  // Next-state logic
  always_comb begin
    period_d       = period_q;
    prescale_d     = prescale_q;
    center_d       = center_q;
    mode_d         = mode_q;
    cmp1_d         = cmp1_q;
    cmp2_d         = cmp2_q;
    psc_d          = psc_q;
    count_d        = count_q;
    dir_d          = dir_q;
    load_pending_d = load_pending_q;
    period_end_d   = 1'b0;
    pwm_d          = '0;

    if (!bus.en) begin
      psc_d          = '0;
      count_d        = '0;
      dir_d          = DIR_UP;
      load_pending_d = 1'b0;
    end else begin
      psc_d = tick ? 8'd0 : psc_q + 8'd1;
      if (tick) begin
        if (period_q == '0) begin
          count_d = '0;
          dir_d   = DIR_UP;
        end else if (!center_q) begin
          count_d = at_top ? '0 : count_q + CNT_ONE;
          dir_d   = DIR_UP;
        end else if (step_down) begin
          count_d = count_q - CNT_ONE;
          dir_d   = (count_q == CNT_ONE) ? DIR_UP : DIR_DOWN;
        end else begin
          count_d = count_q + CNT_ONE;
          dir_d   = DIR_UP;
        end
      end
      period_end_d   = boundary;
      load_pending_d = (load_pending_q || bus.load) && !boundary;
      pwm_d          = bus.ch_en & ch_hit;
    end

    if (copy_cfg) begin
      period_d   = bus.cfg_period;
      prescale_d = bus.cfg_prescale;
      center_d   = bus.cfg_center;
      mode_d     = bus.ch_mode;
      cmp1_d     = bus.ch_cmp1;
      cmp2_d     = bus.ch_cmp2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q       <= '0;
      prescale_q     <= '0;
      center_q       <= 1'b0;
      mode_q         <= '0;
      cmp1_q         <= '0;
      cmp2_q         <= '0;
      psc_q          <= '0;
      count_q        <= '0;
      dir_q          <= DIR_UP;
      load_pending_q <= 1'b0;
      period_end_q   <= 1'b0;
      pwm_q          <= '0;
    end else begin
      period_q       <= period_d;
      prescale_q     <= prescale_d;
      center_q       <= center_d;
      mode_q         <= mode_d;
      cmp1_q         <= cmp1_d;
      cmp2_q         <= cmp2_d;
      psc_q          <= psc_d;
      count_q        <= count_d;
      dir_q          <= dir_d;
      load_pending_q <= load_pending_d;
      period_end_q   <= period_end_d;
      pwm_q          <= pwm_d;
    end
  end

  assign bus.load_pending = load_pending_q;
  assign bus.count        = count_q;
  assign bus.period_end   = period_end_q;
  assign bus.pwm_out      = pwm_q;

endmodule
`default_nettype wire
